// File: rtl/nibble_serial_adder_ctrl.sv
// Serial wide adder: reuses one 4-bit ripple-carry adder, one nibble per clock,
// least-significant nibble first. The inter-nibble carry is held in a register.

module ripple_carry_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[4];
endmodule

// Command handshake: start is accepted on a rising edge while the block is in
// IDLE or DONE; busy is high for the NIBBLES cycles of RUN; done pulses for one
// cycle after Sum/Cout are loaded, and start is ignored while busy.
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 Cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] Sum,
  output logic                 Cout
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = ($clog2(NIBBLES + 1) > 1) ? $clog2(NIBBLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry_q;
  logic [W-1:0]    res_q;
  logic [CW-1:0]   cnt_q;

  logic [3:0]      add_sum;
  logic            add_cout;
  logic [W-1:0]    sum_ext;
  logic [W-1:0]    res_next;
  logic            last_nibble;

  ripple_carry_adder_4bit u_adder (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // New nibble enters at the top so that after NIBBLES shifts nibble 0 sits at the bottom.
  assign sum_ext     = W'(add_sum);
  assign res_next    = (res_q >> 4) | (sum_ext << (W - 4));
  assign last_nibble = (cnt_q == CW'(NIBBLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Sum     <= '0;
      Cout    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= Cin;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          res_q   <= res_next;
          carry_q <= add_cout;
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          cnt_q   <= cnt_q + CW'(1);
          if (last_nibble) begin
            Sum   <= res_next;
            Cout  <= add_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: instances with NIBBLES = 4, 1 and 8, each
// with a cycle-level acceptance model, an expected-result queue and a monitor.

module tb_nibble_serial_adder_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_v [3];
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];
  logic        cin_v [3];
  logic        busy_v [3];
  logic        done_v [3];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, int inst, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h (cycle %0d)", nm, inst, act, exp, cyc);
    end
  endtask

  task automatic drive(int idx, logic st, logic [31:0] a, logic [31:0] b, logic cin);
    start_v[idx] = st;
    a_v[idx]     = a;
    b_v[idx]     = b;
    cin_v[idx]   = cin;
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int N = (g == 0) ? 4 : ((g == 1) ? 1 : 8);
    localparam int W = 4 * N;
    logic [W-1:0] sum_w;
    logic         cout_w;
    logic [32:0]  exp_q [$];
    int           due_q [$];
    int           rem = 0;
    logic [32:0]  hold = '0;

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_v[g]),
      .A     (a_v[g][W-1:0]),
      .B     (b_v[g][W-1:0]),
      .Cin   (cin_v[g]),
      .busy  (busy_v[g]),
      .done  (done_v[g]),
      .Sum   (sum_w),
      .Cout  (cout_w)
    );

    // Reference: an accepted command yields A+B+Cin, due N edges after acceptance.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rem = 0;
        exp_q.delete();
        due_q.delete();
        hold = '0;
      end else if (rem == 0) begin
        if (start_v[g]) begin
          exp_q.push_back(33'({1'b0, a_v[g][W-1:0]} + {1'b0, b_v[g][W-1:0]} + (W+1)'(cin_v[g])));
          due_q.push_back(cyc + 1 + N);
          rem = N;
        end
      end else begin
        rem--;
      end
    end

    always @(negedge clk) begin
      if (rst_n) begin
        bit ed;
        ed = (due_q.size() > 0) && (due_q[0] == cyc);
        check("done", g, 64'(done_v[g]), 64'(ed));
        check("busy", g, 64'(busy_v[g]), 64'(rem != 0));
        if (ed) begin
          hold = exp_q.pop_front();
          void'(due_q.pop_front());
        end
        check("result", g, 64'({cout_w, sum_w}), 64'(hold));
      end
    end
  end

  task automatic run_one(logic [31:0] a, logic [31:0] b, logic cin, logic [16:0] exp);
    int bc = 0;
    int dl = -1;
    @(negedge clk);
    drive(0, 1'b1, a, b, cin);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) drive(0, 1'b0, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
      if (busy_v[0]) bc++;
      if (done_v[0] && dl < 0) dl = i;
    end
    check("busy_cycles", 0, 64'(bc), 64'd4);
    check("done_latency", 0, 64'(dl), 64'd5);
    check("directed_sum", 0, 64'({g_inst[0].cout_w, g_inst[0].sum_w}), 64'(exp));
  endtask

  task automatic rand_run(int idx, int n, int count);
    int issued = 0;
    logic [31:0] a, b;
    while (issued < count) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        drive(idx, 1'b0, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
      end else begin
        a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
        b = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
        drive(idx, 1'b1, a, b, 1'($urandom_range(0, 1)));
        issued++;
        // Start toggles randomly while busy; none of these may be accepted.
        repeat (n) begin
          @(negedge clk);
          drive(idx, 1'($urandom_range(0, 1)), $urandom(), $urandom(), 1'($urandom_range(0, 1)));
        end
      end
    end
    @(negedge clk);
    drive(idx, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    int d1, d2, nd;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, '0, '0, 1'b0);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_busy", i, 64'(busy_v[i]), 64'd0);
      check("reset_done", i, 64'(done_v[i]), 64'd0);
    end
    check("reset_sum", 0, 64'({g_inst[0].cout_w, g_inst[0].sum_w}), 64'd0);
    check("reset_sum", 1, 64'({g_inst[1].cout_w, g_inst[1].sum_w}), 64'd0);
    check("reset_sum", 2, 64'({g_inst[2].cout_w, g_inst[2].sum_w}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_one(32'h1234, 32'h0FF1, 1'b0, 17'h0_2225);
    run_one(32'hFFFF, 32'h0001, 1'b0, 17'h1_0000);
    run_one(32'h5555, 32'hAAAA, 1'b1, 17'h1_0000);
    run_one(32'h5555, 32'hAAAA, 1'b0, 17'h0_FFFF);

    // Start and operand changes while RUN must be ignored.
    @(negedge clk);
    drive(0, 1'b1, 32'h0001, 32'h0002, 1'b0);
    nd = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) drive(0, 1'b0, 32'h7777, 32'h1111, 1'b1);
      if (i == 2) drive(0, 1'b1, 32'hFFFF, 32'h4321, 1'b1);
      if (i == 3) drive(0, 1'b0, 32'h9999, 32'h8888, 1'b0);
      if (i == 3) check("mid_run_hold", 0, 64'({g_inst[0].cout_w, g_inst[0].sum_w}), 64'h0_FFFF);
      if (done_v[0]) nd++;
    end
    check("single_done", 0, 64'(nd), 64'd1);
    check("ignore_sum", 0, 64'({g_inst[0].cout_w, g_inst[0].sum_w}), 64'h0_0003);

    // Back-to-back: start held, second command presented in the DONE cycle.
    @(negedge clk);
    drive(0, 1'b1, 32'h8000, 32'h8000, 1'b0);
    d1 = -1;
    d2 = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done_v[0]) begin
        if (d1 < 0) d1 = i;
        else if (d2 < 0) d2 = i;
      end
      if (i == 5) begin
        check("b2b_first", 0, 64'({g_inst[0].cout_w, g_inst[0].sum_w}), 64'h1_0000);
        drive(0, 1'b1, 32'h0F0F, 32'h00F1, 1'b1);
      end
      if (i == 6) drive(0, 1'b0, '0, '0, 1'b0);
    end
    check("b2b_first_at", 0, 64'(d1), 64'd5);
    check("b2b_gap", 0, 64'(d2 - d1), 64'd5);
    check("b2b_second", 0, 64'({g_inst[0].cout_w, g_inst[0].sum_w}), 64'h0_1001);

    // Asynchronous reset during the second RUN cycle.
    @(negedge clk);
    drive(0, 1'b1, 32'h1234, 32'h4321, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 0, 64'(busy_v[0]), 64'd0);
    check("midrst_done", 0, 64'(done_v[0]), 64'd0);
    check("midrst_sum", 0, 64'({g_inst[0].cout_w, g_inst[0].sum_w}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_one(32'h1111, 32'h2222, 1'b0, 17'h0_3333);

    fork
      rand_run(1, 1, 1000);
      rand_run(2, 8, 1000);
    join
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencer that reuses one `ripple_carry_adder_4bit` instance to add wide operands one nibble per clock, least-significant nibble first, with the inter-nibble carry held in a register. It sits between a requester issuing wide add commands and the 4-bit adder datapath, trading latency for area. Command interface is a start/busy/done handshake; results are registered and held until the next completion.

## Interface
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..16
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  command strobe, sampled on clk rising edge
- A  input  W  operand A, sampled only on the accepting edge
- B  input  W  operand B, sampled only on the accepting edge
- Cin  input  1  carry-in to nibble 0, sampled only on the accepting edge
- busy  output  1  high while a command is in progress (RUN state)
- done  output  1  one-cycle pulse: Sum/Cout just updated
- Sum  output  W  registered result, holds between completions
- Cout  output  1  registered carry-out of the top nibble

## Operation
- Internal: one `ripple_carry_adder_4bit` instance; A/B operand shift registers (W bits each); carry register; result shift register (W bits); nibble counter of ceil(log2(NIBBLES+1)) bits, minimum 1 bit.
- Adder inputs: low nibble of A shift reg, low nibble of B shift reg, carry register.
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. start=1 -> capture A, B; carry <= Cin; counter <= 0; go to RUN.
- RUN: busy=1, done=0. Each edge:
  - shift result reg right by 4, inserting adder Sum at the top.
  - carry <= adder Cout.
  - shift A and B regs right by 4.
  - counter++.
  - On the edge where the counter reaches NIBBLES-1 (the last nibble), load Sum with the completed value (the shifted result including this nibble), load Cout <= adder Cout, and go to DONE.
- DONE: busy=0, done=1 for exactly this cycle. start=1 -> accept a new command exactly as in IDLE and go to RUN. Otherwise go to IDLE.
- start is ignored in RUN: no capture, and the operation in progress is unaffected.
- Sum/Cout change only on the final RUN edge. Intermediate partial sums are never visible on the outputs.
- Arithmetic: {Cout,Sum} = A + B + Cin, modulo 2^(W+1). No overflow flag.
- NIBBLES=1: RUN lasts exactly one edge.

## Timing
- Reset (rst_n low, async): state=IDLE, busy=0, done=0, Sum=0, Cout=0, all internal registers 0. Takes effect immediately, regardless of clk.
- Reset mid-RUN: the command is aborted, done does not pulse, and Sum/Cout read 0.
- Release: first edge with rst_n high may accept start.
- start accepted on edge k:
  - busy=1 from k through k+NIBBLES (busy is high for exactly NIBBLES cycles).
  - Sum/Cout update at edge k+NIBBLES.
  - done=1 in the cycle following edge k+NIBBLES.
- Latency: NIBBLES cycles from the accepting edge to done.
- Back-to-back: start held high continuously gives one completion every NIBBLES+1 cycles.
- A/B/Cin may change freely after the accepting edge.

## Test plan
- NIBBLES=4: A=0x1234, B=0x0FF1, Cin=0, start pulsed -> busy high for 4 cycles, done pulses 4 cycles after the accepting edge, Sum=0x2225, Cout=0.
- Full carry ripple across nibbles: A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1. Then A=0x5555, B=0xAAAA, Cin=1 -> Sum=0x0000, Cout=1. Then A=0x5555, B=0xAAAA, Cin=0 -> Sum=0xFFFF, Cout=0.
- Start during RUN and changing operands mid-RUN:
  - Issue 0x0001+0x0002 with Cin=0.
  - Assert start on cycle 2 with A=0xFFFF, and change the operands.
  - Required: result is Sum=0x0003, Cout=0; only one done pulse; Sum stays stable at its previous value until the done edge.
- Back-to-back: start held high with 0x8000+0x8000 and Cin=0, then 0x0F0F+0x00F1 and Cin=1 presented in the DONE cycle.
  - First result: Sum=0x0000, Cout=1.
  - Second result: Sum=0x1001, Cout=0, done exactly 5 cycles after the first done.
- Reset mid-operation: rst_n low during the 2nd RUN cycle -> busy, done, Sum and Cout go to 0 immediately with no done pulse; a new command after release completes correctly.
- NIBBLES=1 (and NIBBLES=8): 1000 random operand/Cin sets checked against the behavioural sum; done latency equals NIBBLES.
